st2cl_post_afu: RTL

Stream-to-cache-line packer on the AFU output side: the transmit-direction counterpart of the pre-AFU cache-line-to-stream path. Accepts ST-wide sample words framed by sop/eop from the AFU, packs them MSB-first into 512-bit cache lines carrying the 16-bit CL header (sop/eop flags, valid-word count), and presents each completed line on a valid/ready source port toward the host write buffer.

---
 rtl/st2cl_pkg.sv | 52 +++++
 rtl/st2cl_post_afu_cl_out_reg.sv | 47 ++++
 rtl/st2cl_post_afu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/st2cl_pkg.sv
// st2cl_pkg
//   Shared constants, header layout and FSM state type for the
//   stream-to-cache-line packer (st2cl_post_afu).
//   Line layout, MSB first:
//     [CL-1 : CL-4]    reserved, always zero
//     [CL-5 : CL-6]    {first, last} flags
//     [CL-7 : CL-16]   number of valid stream words in the line
//     [CL_PAYLOAD-1:0] payload, word k at [CL_PAYLOAD-1-k*ST -: ST],
//                      followed by PAD zero bits at the bottom
package st2cl_pkg;

    localparam int CL         = 512;
    localparam int CL_HEAD    = 16;
    localparam int CL_PAYLOAD = CL - CL_HEAD;
    localparam int ST         = 12;
    localparam int W_LEN      = 10;
    localparam int N_ST       = CL_PAYLOAD / ST;        // 41 words per line
    localparam int PAD        = CL_PAYLOAD - N_ST * ST; // 4 unused bits

    // Word counter must hold 0..N_ST
    localparam int                WCNT_W = 6;
    localparam logic [WCNT_W-1:0] N_ST_W = WCNT_W'(N_ST);

    // Absolute bit positions of the header fields within the line
    localparam int FLAG_HI = CL - 5;
    localparam int LEN_HI  = CL - 7;

    // {first, last} encodings
    localparam logic [1:0] FL_FIRST  = 2'b10;
    localparam logic [1:0] FL_MID    = 2'b00;
    localparam logic [1:0] FL_LAST   = 2'b01;
    localparam logic [1:0] FL_SINGLE = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_FRM = 1'b1
    } state_t;

    // Build the 16-bit header from the flag pair and the valid-word count.
    // Field positions are taken relative to the bottom of the header.
    function automatic logic [CL_HEAD-1:0] make_header(
        input logic [1:0]        flags,
        input logic [WCNT_W-1:0] cnt
    );
        logic [CL_HEAD-1:0] hdr;
        hdr = '0;
        hdr[FLAG_HI-CL_PAYLOAD -: 2]    = flags;
        hdr[LEN_HI-CL_PAYLOAD -: W_LEN] = W_LEN'(cnt);
        return hdr;
    endfunction

endpackage

// File: rtl/st2cl_post_afu_cl_out_reg.sv
// cl_out_reg
//   Single-entry output holding register with a valid/ready source port.
//   A new entry may be loaded in the same cycle the current one drains,
//   so back-to-back lines flow without a bubble.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     i_load       load i_data this cycle (only legal when o_in_ready)
//     i_data       entry to be held
//     o_in_ready   register is empty or draining this cycle
//     o_valid      entry held
//     o_data       held entry (stable while o_valid && !i_ready)
//     i_ready      downstream accepts the held entry
import st2cl_pkg::*;

module cl_out_reg #(
    parameter int W = CL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_in_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_in_ready = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/st2cl_post_afu.sv
// st2cl_post_afu
//   Packs ST-bit stream words framed by sop/eop into CL-bit cache lines
//   (16-bit header + MSB-first payload) and presents each completed line
//   on a valid/ready source port. A line closes when it holds N_ST words
//   or when the frame ends.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     sink_valid     stream word valid
//     sink_data      stream word (ST bits)
//     sink_sop       first word of a frame
//     sink_eop       last word of a frame
//     sink_ready     packer accepts a word this cycle
//     source_valid   cache line valid
//     source_data    cache line (header + payload)
//     source_ready   downstream accepts the line
//     frm_err        one-cycle pulse on a framing violation
import st2cl_pkg::*;

module st2cl_post_afu (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sink_valid,
    input  logic [ST-1:0] sink_data,
    input  logic          sink_sop,
    input  logic          sink_eop,
    output logic          sink_ready,
    output logic          source_valid,
    output logic [CL-1:0] source_data,
    input  logic          source_ready,
    output logic          frm_err
);

    state_t              r_state;
    state_t              w_state_next;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_next;
    logic [WCNT_W-1:0]   w_wr_idx;
    logic [WCNT_W-1:0]   w_cnt_after;
    logic                r_first_pend;
    logic                w_first_pend_next;
    logic                r_frm_err;
    logic                w_frm_err_next;

    logic                w_accept;
    logic                w_start;
    logic                w_append;
    logic                w_close;
    logic                w_first;
    logic                w_last;
    logic                w_in_ready;
    logic [1:0]          w_flags;

    logic [ST-1:0]       r_acc  [N_ST];
    logic [ST-1:0]       w_slot [N_ST];
    logic [CL_PAYLOAD-1:0] w_payload;
    logic [CL-1:0]       w_line;

    // Every word, closing or not, waits for the output register to have
    // room; that keeps a closing word from ever landing on an undrained line.
    assign sink_ready = w_in_ready;
    assign w_accept   = sink_valid && w_in_ready;
    assign frm_err    = r_frm_err;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_wcnt_next       = r_wcnt;
        w_first_pend_next = r_first_pend;
        w_frm_err_next    = 1'b0;
        w_start           = 1'b0;
        w_append          = 1'b0;
        w_close           = 1'b0;
        w_last            = 1'b0;
        w_wr_idx          = r_wcnt;
        w_cnt_after       = r_wcnt + WCNT_W'(1);

        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (sink_sop) begin
                        w_start = 1'b1;
                    end else begin
                        // Word outside any frame: drop it
                        w_frm_err_next = 1'b1;
                    end
                end
                S_IN_FRM: begin
                    if (sink_sop) begin
                        // Restarted frame: abandon the partial line
                        w_start        = 1'b1;
                        w_frm_err_next = 1'b1;
                    end else begin
                        w_append = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end

        if (w_start) begin
            w_wr_idx          = '0;
            w_cnt_after       = WCNT_W'(1);
            w_wcnt_next       = WCNT_W'(1);
            w_first_pend_next = 1'b1;
            w_state_next      = S_IN_FRM;
            w_close           = sink_eop;
        end

        if (w_append) begin
            w_wcnt_next = w_cnt_after;
            w_close     = sink_eop || (w_cnt_after == N_ST_W);
        end

        if (w_close) begin
            w_last            = sink_eop;
            w_wcnt_next       = '0;
            w_first_pend_next = 1'b0;
            w_state_next      = sink_eop ? S_IDLE : S_IN_FRM;
        end
    end

    // A frame that starts and closes on the same word is always "first"
    assign w_first = w_start || r_first_pend;
    assign w_flags = w_first ? (w_last ? FL_SINGLE : FL_FIRST)
                             : (w_last ? FL_LAST   : FL_MID);

    // ------------------------------------------------------------------
    // Accumulator slots: the incoming word merged into the stored words.
    // On a frame start all other slots read as zero so a discarded
    // partial line never leaks into the new one.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_ST; gi++) begin : g_slot
            logic w_hit;
            assign w_hit = (w_start || w_append) && (w_wr_idx == WCNT_W'(gi));
            assign w_slot[gi] = w_hit   ? sink_data :
                                w_start ? '0        : r_acc[gi];
            assign w_payload[CL_PAYLOAD-1-gi*ST -: ST] = w_slot[gi];
        end
    endgenerate

    assign w_payload[PAD-1:0] = '0;
    assign w_line = {make_header(w_flags, w_cnt_after), w_payload};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wcnt       <= '0;
            r_first_pend <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wcnt       <= w_wcnt_next;
            r_first_pend <= w_first_pend_next;
            r_frm_err    <= w_frm_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_close) begin
            for (int i = 0; i < N_ST; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_acc <= w_slot;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------
    cl_out_reg #(
        .W (CL)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_close),
        .i_data     (w_line),
        .o_in_ready (w_in_ready),
        .o_valid    (source_valid),
        .o_data     (source_data),
        .i_ready    (source_ready)
    );

endmodule
